// File: rtl/debug_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_packer
// Description : Buffers tagged 16-bit sensor readings and packs each into a
//               6-byte frame {A5, tag, val_hi, val_lo, seq, csum} for the
//               debug UART stage, with an idle heartbeat frame.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_packer #(
  parameter int FIFO_DEPTH        = 4,
  parameter int FRAME_HOLD_CYCLES = 2048,
  parameter int HEARTBEAT_CYCLES  = 33_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_tag,
  input  logic [15:0] in_value,
  output logic [47:0] frame_data,
  output logic        frame_de,
  output logic        busy
);

  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_HOLD_W = (FRAME_HOLD_CYCLES > 1) ? $clog2(FRAME_HOLD_CYCLES) : 1;
  localparam int c_HB_W   = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam bit c_HB_EN  = (HEARTBEAT_CYCLES > 0);

  localparam logic [c_ADDR_W:0]   c_DEPTH     = (c_ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(FRAME_HOLD_CYCLES - 1);
  localparam logic [c_HB_W-1:0]   c_HB_LAST   = c_HB_W'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_HOLD = 1'b1;

  logic [23:0]         r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;
  logic                r_ready;

  logic [0:0]          r_state;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_HB_W-1:0]   r_hb_cnt;
  logic                r_hb_arm;
  logic [7:0]          r_seq;
  logic [47:0]         r_frame;
  logic                r_de;

  logic                w_push;
  logic                w_pop;
  logic                w_hb_fire;
  logic [c_ADDR_W:0]   w_count_nxt;
  logic [23:0]         w_head;
  logic [7:0]          w_tag;
  logic [15:0]         w_val;
  logic [7:0]          w_csum;

  assign w_push      = in_valid & r_ready;
  assign w_pop       = (r_state == c_IDLE) && (r_count != '0);
  assign w_count_nxt = r_count + {{c_ADDR_W{1'b0}}, w_push} - {{c_ADDR_W{1'b0}}, w_pop};

  // Heartbeat only when nothing is queued, so a pending reading always wins.
  assign w_hb_fire = c_HB_EN && (r_state == c_IDLE) && (r_count == '0)
                     && r_hb_arm && (r_hb_cnt == c_HB_LAST);

  assign w_head = r_mem[r_rd_ptr];
  assign w_tag  = w_pop ? w_head[23:16] : 8'hFF;
  assign w_val  = w_pop ? w_head[15:0]  : 16'h0000;
  assign w_csum = 8'hA5 + w_tag + w_val[15:8] + w_val[7:0] + r_seq;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_tag, in_value};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != c_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_hold_cnt <= '0;
      r_hb_cnt   <= '0;
      r_hb_arm   <= 1'b1;
      r_seq      <= 8'h00;
      r_frame    <= 48'h0;
      r_de       <= 1'b0;
    end else begin
      r_de <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_pop || w_hb_fire) begin
            r_frame    <= {8'hA5, w_tag, w_val, r_seq, w_csum};
            r_de       <= 1'b1;
            r_seq      <= r_seq + 8'd1;
            r_hb_cnt   <= '0;
            r_hold_cnt <= '0;
            r_state    <= c_HOLD;
          end else begin
            // The first idle cycle after a hold is turnaround; idle time counts from the next.
            r_hb_arm <= 1'b1;
            if (r_hb_arm) r_hb_cnt <= r_hb_cnt + c_HB_W'(1);
          end
        end
        default: begin
          r_hb_cnt <= '0;
          r_hb_arm <= 1'b0;
          if (r_hold_cnt == c_HOLD_LAST) begin
            r_state <= c_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
          end
        end
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign frame_data = r_frame;
  assign frame_de   = r_de;
  assign busy       = (r_state == c_HOLD);

endmodule
`default_nettype wire
